// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush, optional jump squash (NOP bubble) and a saturating squash counter.
module if_id_pipe_reg #(
    parameter int unsigned          INSTR_W    = 8,
    parameter int unsigned          PC_W       = 8,
    parameter logic [INSTR_W-1:0]   JUMP_MASK  = 8'hC0,
    parameter logic [INSTR_W-1:0]   JUMP_MATCH = 8'hC0,
    parameter logic [INSTR_W-1:0]   NOP_CODE   = 8'h00,
    parameter bit                   SQUASH_EN  = 1'b1,
    parameter int unsigned          CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               jump_detect,
    output logic [CNT_W-1:0]   squash_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e             state_q,       state_d;
    logic               in_ready_q,    in_ready_d;
    logic [INSTR_W-1:0] out_instr_q,   out_instr_d;
    logic [PC_W-1:0]    out_pc_q,      out_pc_d;
    logic [INSTR_W-1:0] skid_instr_q,  skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q,     skid_pc_d;
    logic               jump_detect_q, jump_detect_d;
    logic [CNT_W-1:0]   squash_cnt_q,  squash_cnt_d;

    logic               accept;
    logic               consume;
    logic               is_jump;
    logic               squash;
    logic [INSTR_W-1:0] stored_instr;

    // Flush masks the handshake so nothing presented in the flush cycle is captured.
    assign accept       = in_valid & in_ready_q & ~flush;
    assign consume      = (state_q != EMPTY) & out_ready;
    assign is_jump      = ((in_instr & JUMP_MASK) == JUMP_MATCH);
    assign squash       = SQUASH_EN & is_jump;
    assign stored_instr = squash ? NOP_CODE : in_instr;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave it
        // unassigned and infer a latch.
        state_d       = state_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        jump_detect_d = accept & squash;
        squash_cnt_d  = squash_cnt_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = MAIN;
                    out_instr_d = stored_instr;
                    out_pc_d    = in_pc;
                end
            end
            MAIN: begin
                if (accept && consume) begin
                    out_instr_d = stored_instr;
                    out_pc_d    = in_pc;
                end else if (accept) begin
                    state_d      = FULL;
                    skid_instr_d = stored_instr;
                    skid_pc_d    = in_pc;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path exists; the skid entry
                // is always younger than the output entry.
                if (consume) begin
                    state_d     = MAIN;
                    out_instr_d = skid_instr_q;
                    out_pc_d    = skid_pc_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (flush) begin
            state_d     = EMPTY;
            out_instr_d = NOP_CODE;
        end

        if (accept && squash && (squash_cnt_q != {CNT_W{1'b1}})) begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
        end

        in_ready_d = (state_d != FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= EMPTY;
            in_ready_q    <= 1'b1;
            out_instr_q   <= NOP_CODE;
            out_pc_q      <= '0;
            jump_detect_q <= 1'b0;
            squash_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            jump_detect_q <= jump_detect_d;
            squash_cnt_q  <= squash_cnt_d;
        end
    end

    // NOTE: skid payload carries no reset; it is only ever read while the state says
    // the skid entry is valid, so its contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign jump_detect = jump_detect_q;
    assign squash_cnt  = squash_cnt_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: default instance, a SQUASH_EN=0 instance and a
// CNT_W=2 instance share one stimulus stream and are checked against a reference queue.
module tb_if_id_pipe_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_instr;
    logic [7:0] in_pc;
    logic       flush;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_jd;
    logic [7:0] a_instr, a_pc, a_cnt;
    logic       b_in_ready, b_out_valid, b_jd;
    logic [7:0] b_instr, b_pc, b_cnt;
    logic       c_in_ready, c_out_valid, c_jd;
    logic [7:0] c_instr, c_pc;
    logic [1:0] c_cnt;

    always #5 clk = ~clk;

    if_id_pipe_reg dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_instr(a_instr), .out_pc(a_pc),
        .jump_detect(a_jd), .squash_cnt(a_cnt)
    );

    if_id_pipe_reg #(.SQUASH_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_instr(b_instr), .out_pc(b_pc),
        .jump_detect(b_jd), .squash_cnt(b_cnt)
    );

    if_id_pipe_reg #(.CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_instr(c_instr), .out_pc(c_pc),
        .jump_detect(c_jd), .squash_cnt(c_cnt)
    );

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] pc;
    } ent_t;

    ent_t        sb_q[$];
    bit          rdy_m;
    bit          jd_m;
    int unsigned cnt_a;
    int unsigned cnt_c;
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_jump(input logic [7:0] instr);
        return (instr & 8'hC0) == 8'hC0;
    endfunction

    task automatic check_all();
        logic       v;
        logic [7:0] raw;
        logic [7:0] sq;
        v = (sb_q.size() > 0);
        check("a_valid", a_out_valid, v);
        check("b_valid", b_out_valid, v);
        check("c_valid", c_out_valid, v);
        check("a_in_ready", a_in_ready, rdy_m);
        check("b_in_ready", b_in_ready, rdy_m);
        check("c_in_ready", c_in_ready, rdy_m);
        check("a_jump_detect", a_jd, jd_m);
        check("b_jump_detect", b_jd, 1'b0);
        check("c_jump_detect", c_jd, jd_m);
        check("a_squash_cnt", a_cnt, cnt_a);
        check("b_squash_cnt", b_cnt, 0);
        check("c_squash_cnt", c_cnt, cnt_c);
        if (v) begin
            raw = sb_q[0].instr;
            sq  = is_jump(raw) ? 8'h00 : raw;
            check("a_out_instr", a_instr, sq);
            check("b_out_instr", b_instr, raw);
            check("c_out_instr", c_instr, sq);
            check("a_out_pc", a_pc, sb_q[0].pc);
            check("b_out_pc", b_pc, sb_q[0].pc);
            check("c_out_pc", c_pc, sb_q[0].pc);
        end
    endtask

    // One clock: drive on negedge, update the reference at posedge, compare #1 later.
    task automatic step(input bit iv, input logic [7:0] instr, input logic [7:0] pc,
                        input bit fl, input bit ordy);
        bit acc;
        bit cons;
        @(negedge clk);
        in_valid  = iv;
        in_instr  = instr;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        acc  = iv && rdy_m && !fl;
        cons = (sb_q.size() > 0) && ordy;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (cons) void'(sb_q.pop_front());
            if (acc) sb_q.push_back('{instr: instr, pc: pc});
        end
        jd_m = acc && is_jump(instr);
        if (jd_m) begin
            if (cnt_a < 255) cnt_a++;
            if (cnt_c < 3) cnt_c++;
        end
        rdy_m = (sb_q.size() != 2);
        #1;
        check_all();
    endtask

    task automatic model_reset();
        sb_q.delete();
        rdy_m = 1'b1;
        jd_m  = 1'b0;
        cnt_a = 0;
        cnt_c = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 8'h00;
        in_pc     = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_all();
        check("rst_out_instr", a_instr, 8'h00);
        check("rst_out_pc", a_pc, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back stream with decode always ready
        step(1'b1, 8'h12, 8'h10, 1'b0, 1'b1);
        step(1'b1, 8'h34, 8'h11, 1'b0, 1'b1);
        step(1'b1, 8'h56, 8'h12, 1'b0, 1'b1);
        idle(2);

        // Backpressure fills the skid, then drains in order
        step(1'b1, 8'h12, 8'h20, 1'b0, 1'b0);
        step(1'b1, 8'h34, 8'h21, 1'b0, 1'b0);
        step(1'b1, 8'h56, 8'h22, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        idle(3);

        // Jump squash
        step(1'b1, 8'hC5, 8'h20, 1'b0, 1'b1);
        idle(2);

        // Flush while FULL (jump held in skid), then flush masking an accept in MAIN
        step(1'b1, 8'hAA, 8'h30, 1'b0, 1'b0);
        step(1'b1, 8'hC1, 8'h31, 1'b0, 1'b0);
        step(1'b1, 8'h77, 8'h32, 1'b1, 1'b0);
        step(1'b1, 8'hBB, 8'h40, 1'b0, 1'b0);
        step(1'b1, 8'hC7, 8'h41, 1'b1, 1'b0);
        idle(2);

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hC0 + 8'(i), 8'h50 + 8'(i), 1'b0, 1'b1);
        end
        idle(2);

        // Asynchronous reset while FULL
        step(1'b1, 8'h11, 8'h60, 1'b0, 1'b0);
        step(1'b1, 8'h22, 8'h61, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst2_out_instr", a_instr, 8'h00);
        check("rst2_out_pc", a_pc, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        step(1'b1, 8'h33, 8'h70, 1'b0, 1'b1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
